// File: rtl/mdio_master.sv
// MDIO management master: builds Clause 22/45 frames on split tristate pins,
// derives MDC from clk and flags absent PHYs via the turnaround bit.
module mdio_master #(
    parameter int CLK_DIV     = 10,
    parameter int PRE_LEN     = 32,
    parameter bit SUPPORT_C45 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cyc_i,
    input  logic        c45_i,
    input  logic [1:0]  cmd_i,
    input  logic [4:0]  phy_adr_i,
    input  logic [4:0]  reg_adr_i,
    input  logic [15:0] dat_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [15:0] dat_o,
    output logic        busy_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);
    localparam int               DIV_W      = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       PRE_END    = 6'(PRE_LEN);
    localparam logic [5:0]       TA_FIRST   = 6'(PRE_LEN + 14);
    localparam logic [5:0]       TA_LAST    = 6'(PRE_LEN + 15);
    localparam logic [5:0]       DATA_FIRST = 6'(PRE_LEN + 16);
    localparam logic [5:0]       LAST_BIT   = 6'(PRE_LEN + 31);

    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_HDR, ST_TA, ST_DATA, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [5:0]       bit_q, bit_d, bit_nxt;
    logic [DIV_W-1:0] div_q, div_d;
    logic             mdc_q, mdc_d, mdio_q, mdio_d, oe_q, oe_d;
    logic [31:0]      sh_q, sh_d;
    logic [15:0]      rx_q, rx_d, dat_q, dat_d;
    logic             err_q, err_d, rd_q, rd_d;
    logic [1:0]       sync_q;
    logic             mdio_sync;
    logic             reject, is_read;
    logic [1:0]       st, op;
    logic [31:0]      frame;

    // The pad is idle-high (pull-up), so the synchroniser resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], mdio_i};
    end
    assign mdio_sync = sync_q[1];

    always_comb begin
        reject  = c45_i ? !SUPPORT_C45 : !cmd_i[0];
        is_read = cmd_i[1];
        st      = c45_i ? 2'b00 : 2'b01;
        op      = c45_i ? cmd_i : (cmd_i[1] ? 2'b10 : 2'b01);
        // Read frames keep ones after RA; the line is released there anyway.
        frame   = {st, op, phy_adr_i, reg_adr_i, is_read ? 18'h3FFFF : {2'b10, dat_i}};
    end

    always_comb begin
        // NOTE: every next-state signal gets a default here so no latch is inferred.
        state_d = state_q;
        bit_d   = bit_q;
        div_d   = div_q;
        mdc_d   = mdc_q;
        mdio_d  = mdio_q;
        oe_d    = oe_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        err_d   = err_q;
        rd_d    = rd_q;
        dat_d   = dat_q;
        bit_nxt = bit_q + 6'd1;
        case (state_q)
            ST_IDLE: begin
                mdc_d  = 1'b0;
                mdio_d = 1'b1;
                oe_d   = 1'b0;
                err_d  = 1'b0;
                if (cyc_i) begin
                    rd_d = is_read;
                    if (reject) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = (PRE_LEN > 0) ? ST_PRE : ST_HDR;
                        bit_d   = '0;
                        div_d   = '0;
                        sh_d    = frame;
                        oe_d    = 1'b1;
                        mdio_d  = (PRE_LEN > 0) ? 1'b1 : frame[31];
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    mdc_d = !mdc_q;
                    if (!mdc_q) begin
                        // Rising MDC: sample the PHY.
                        if (rd_q && state_q == ST_TA && bit_q == TA_LAST) err_d = mdio_sync;
                        if (rd_q && state_q == ST_DATA) rx_d = {rx_q[14:0], mdio_sync};
                    end else if (bit_q == LAST_BIT) begin
                        state_d = ST_DONE;
                        mdio_d  = 1'b1;
                        oe_d    = 1'b0;
                        if (rd_q) dat_d = rx_q;
                    end else begin
                        bit_d = bit_nxt;
                        if (state_q != ST_PRE) sh_d = {sh_q[30:0], 1'b1};
                        if (state_q == ST_PRE && bit_nxt == PRE_END)    state_d = ST_HDR;
                        if (state_q == ST_HDR && bit_nxt == TA_FIRST)   state_d = ST_TA;
                        if (state_q == ST_TA  && bit_nxt == DATA_FIRST) state_d = ST_DATA;
                        mdio_d = (state_d == ST_PRE) ? 1'b1 : sh_d[31];
                        oe_d   = !(rd_q && (state_d == ST_TA || state_d == ST_DATA));
                    end
                end
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments; the async reset also releases the pad at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            div_q   <= '0;
            mdc_q   <= 1'b0;
            mdio_q  <= 1'b1;
            oe_q    <= 1'b0;
            sh_q    <= '0;
            rx_q    <= '0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            mdc_q   <= mdc_d;
            mdio_q  <= mdio_d;
            oe_q    <= oe_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            dat_q   <= dat_d;
        end
    end

    assign ack_o     = (state_q == ST_DONE);
    assign err_o     = ack_o && err_q;
    assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign dat_o     = dat_q;
    assign mdc_o     = mdc_q;
    assign mdio_o    = mdio_q;
    assign mdio_oe_o = oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: three instances (default-like, no-preamble,
// no-C45) share stimulus; a monitor captures frames and models the PHY.
module tb_mdio_master;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc   = 1'b0;
    logic        c45   = 1'b0;
    logic [1:0]  cmd   = 2'b00;
    logic [4:0]  pa    = '0;
    logic [4:0]  ra    = '0;
    logic [15:0] din   = '0;
    logic        mdio_i = 1'b1;
    int          sel   = 0;

    int checks = 0;
    int errors = 0;

    logic        cyc_a, cyc_b, cyc_c;
    logic        ack_a, err_a, busy_a, mdc_a, mdio_a, oe_a;
    logic        ack_b, err_b, busy_b, mdc_b, mdio_b, oe_b;
    logic        ack_c, err_c, busy_c, mdc_c, mdio_c, oe_c;
    logic [15:0] dat_a, dat_b, dat_c;

    assign cyc_a = cyc && (sel == 0);
    assign cyc_b = cyc && (sel == 1);
    assign cyc_c = cyc && (sel == 2);

    always #5 clk = ~clk;

    mdio_master #(.CLK_DIV(2), .PRE_LEN(32), .SUPPORT_C45(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .cyc_i(cyc_a), .c45_i(c45), .cmd_i(cmd),
        .phy_adr_i(pa), .reg_adr_i(ra), .dat_i(din), .ack_o(ack_a), .err_o(err_a),
        .dat_o(dat_a), .busy_o(busy_a), .mdc_o(mdc_a), .mdio_o(mdio_a),
        .mdio_oe_o(oe_a), .mdio_i(mdio_i));

    mdio_master #(.CLK_DIV(3), .PRE_LEN(0), .SUPPORT_C45(1'b1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .cyc_i(cyc_b), .c45_i(c45), .cmd_i(cmd),
        .phy_adr_i(pa), .reg_adr_i(ra), .dat_i(din), .ack_o(ack_b), .err_o(err_b),
        .dat_o(dat_b), .busy_o(busy_b), .mdc_o(mdc_b), .mdio_o(mdio_b),
        .mdio_oe_o(oe_b), .mdio_i(mdio_i));

    mdio_master #(.CLK_DIV(2), .PRE_LEN(32), .SUPPORT_C45(1'b0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .cyc_i(cyc_c), .c45_i(c45), .cmd_i(cmd),
        .phy_adr_i(pa), .reg_adr_i(ra), .dat_i(din), .ack_o(ack_c), .err_o(err_c),
        .dat_o(dat_c), .busy_o(busy_c), .mdc_o(mdc_c), .mdio_o(mdio_c),
        .mdio_oe_o(oe_c), .mdio_i(mdio_i));

    logic        cur_ack, cur_err, cur_busy, cur_mdc, cur_mdio, cur_oe;
    logic [15:0] cur_dat;
    int          cur_pre;

    always_comb begin
        cur_pre = (sel == 1) ? 0 : 32;
        case (sel)
            1:       {cur_ack, cur_err, cur_busy, cur_mdc, cur_mdio, cur_oe, cur_dat} = {ack_b, err_b, busy_b, mdc_b, mdio_b, oe_b, dat_b};
            2:       {cur_ack, cur_err, cur_busy, cur_mdc, cur_mdio, cur_oe, cur_dat} = {ack_c, err_c, busy_c, mdc_c, mdio_c, oe_c, dat_c};
            default: {cur_ack, cur_err, cur_busy, cur_mdc, cur_mdio, cur_oe, cur_dat} = {ack_a, err_a, busy_a, mdc_a, mdio_a, oe_a, dat_a};
        endcase
    end

    // Frame monitor and PHY model: the PHY updates the line right after each
    // rising MDC so the value is stable at the master's next rising edge.
    int          rise_cnt    = 0;
    int          cyc_cnt     = 0;
    int          oe_fall_cyc = -1;
    int          oe_lo_cnt   = 0;
    int          pre_bad     = 0;
    int          mdc_rises   = 0;
    logic [31:0] frame_bits  = '0;
    logic        phy_on      = 1'b0;
    logic [15:0] phy_data    = '0;
    logic        busy_prev   = 1'b0;
    logic        mdc_prev    = 1'b0;

    always @(negedge clk) begin
        if (cur_mdc && !mdc_prev) mdc_rises++;
        if (cur_busy && !busy_prev) begin
            rise_cnt    = 0;
            cyc_cnt     = 0;
            oe_fall_cyc = -1;
            oe_lo_cnt   = 0;
            pre_bad     = 0;
            frame_bits  = '0;
        end
        if (cur_busy) begin
            cyc_cnt++;
            if (!cur_oe) begin
                oe_lo_cnt++;
                if (oe_fall_cyc < 0) oe_fall_cyc = cyc_cnt;
            end
            if (cur_mdc && !mdc_prev) begin
                if (rise_cnt < cur_pre) begin
                    if (cur_mdio !== 1'b1) pre_bad++;
                end else if (rise_cnt < cur_pre + 32) begin
                    frame_bits[31 - (rise_cnt - cur_pre)] = cur_mdio;
                end
                if (phy_on) begin
                    if (rise_cnt == cur_pre + 14) mdio_i = 1'b0;
                    else if (rise_cnt >= cur_pre + 15 && rise_cnt <= cur_pre + 30)
                        mdio_i = phy_data[30 - rise_cnt + cur_pre];
                    else if (rise_cnt == cur_pre + 31) mdio_i = 1'b1;
                end
                rise_cnt++;
            end
        end
        busy_prev = cur_busy;
        mdc_prev  = cur_mdc;
    end

    // Issues one request, scrambles the inputs after acceptance, waits for ack.
    task automatic run_frame(input logic c45v, input logic [1:0] cmdv, input logic [4:0] pav,
                             input logic [4:0] rav, input logic [15:0] dv, input logic hold,
                             output int lat, output logic errv, output logic [15:0] datv,
                             output logic ctl_ok);
        @(negedge clk);
        c45 = c45v; cmd = cmdv; pa = pav; ra = rav; din = dv; cyc = 1'b1;
        lat = 0;
        ctl_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                c45 = ~c45; cmd = ~cmd; pa = ~pa; ra = ~ra; din = ~din;
            end
            if (!cur_ack && !cur_busy) ctl_ok = 1'b0;
            if (cur_ack && (cur_busy || cur_mdc)) ctl_ok = 1'b0;
        end while (!cur_ack && lat < 3000);
        errv = cur_err;
        datv = cur_dat;
        if (!hold) cyc = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            checks++;
            if ({cur_mdc, cur_mdio, cur_oe, cur_ack, cur_err, cur_busy, cur_dat} !== {6'b010000, 16'h0000}) begin
                errors++;
                $display("FAIL reset_values dut%0d: got mdc=%b mdio=%b oe=%b ack=%b err=%b busy=%b dat=%h, expected 0 1 0 0 0 0 0000",
                         i, cur_mdc, cur_mdio, cur_oe, cur_ack, cur_err, cur_busy, cur_dat);
            end
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_c22_write();
        int lat; logic e; logic [15:0] d; logic ok;
        sel = 0; phy_on = 1'b0;
        run_frame(1'b0, 2'b01, 5'h01, 5'h00, 16'h8000, 1'b0, lat, e, d, ok);
        checks++; if (lat !== 257) begin errors++; $display("FAIL c22_wr_ack_cycle: got %0d expected 257", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL c22_wr_err: got %b expected 0", e); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL c22_wr_busy_mdc: got %b expected 1", ok); end
        checks++; if (pre_bad !== 0 || rise_cnt !== 64) begin errors++; $display("FAIL c22_wr_preamble: got bad=%0d rises=%0d expected 0 64", pre_bad, rise_cnt); end
        checks++; if (frame_bits !== 32'h5082_8000) begin errors++; $display("FAIL c22_wr_frame: got %h expected 50828000", frame_bits); end
        checks++; if (oe_lo_cnt !== 0) begin errors++; $display("FAIL c22_wr_oe: got %0d released cycles expected 0", oe_lo_cnt); end
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL c22_wr_dat_kept: got %h expected 0000", d); end
    endtask

    task automatic test_c22_read();
        int lat; logic e; logic [15:0] d; logic ok;
        sel = 0; phy_on = 1'b1; phy_data = 16'h1234;
        run_frame(1'b0, 2'b11, 5'h03, 5'h02, 16'h0000, 1'b0, lat, e, d, ok);
        checks++; if (lat !== 257) begin errors++; $display("FAIL c22_rd_ack_cycle: got %0d expected 257", lat); end
        checks++; if (frame_bits[31:18] !== 14'h1862) begin errors++; $display("FAIL c22_rd_header: got %h expected 1862", frame_bits[31:18]); end
        checks++; if (oe_fall_cyc !== 185) begin errors++; $display("FAIL c22_rd_oe_fall: got %0d expected 185", oe_fall_cyc); end
        checks++; if (oe_lo_cnt !== 72) begin errors++; $display("FAIL c22_rd_oe_len: got %0d expected 72", oe_lo_cnt); end
        checks++; if (d !== 16'h1234) begin errors++; $display("FAIL c22_rd_data: got %h expected 1234", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL c22_rd_err: got %b expected 0", e); end
    endtask

    task automatic test_no_phy();
        int lat; logic e; logic [15:0] d; logic ok;
        sel = 0; phy_on = 1'b0;
        run_frame(1'b0, 2'b11, 5'h05, 5'h01, 16'h0000, 1'b0, lat, e, d, ok);
        checks++; if (lat !== 257) begin errors++; $display("FAIL nophy_ack_cycle: got %0d expected 257", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL nophy_err: got %b expected 1", e); end
        checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL nophy_data: got %h expected ffff", d); end
    endtask

    task automatic test_c45();
        int lat; logic e; logic [15:0] d; logic ok;
        sel = 0; phy_on = 1'b0;
        run_frame(1'b1, 2'b00, 5'h02, 5'h01, 16'h0010, 1'b0, lat, e, d, ok);
        checks++; if (frame_bits !== 32'h0106_0010) begin errors++; $display("FAIL c45_addr_frame: got %h expected 01060010", frame_bits); end
        checks++; if (e !== 1'b0 || d !== 16'hFFFF) begin errors++; $display("FAIL c45_addr_ack: got err=%b dat=%h expected 0 ffff", e, d); end
        phy_on = 1'b1; phy_data = 16'hBEEF;
        run_frame(1'b1, 2'b10, 5'h02, 5'h01, 16'h0000, 1'b0, lat, e, d, ok);
        checks++; if (frame_bits[31:18] !== 14'h0841) begin errors++; $display("FAIL c45_rdinc_header: got %h expected 0841", frame_bits[31:18]); end
        checks++; if (oe_fall_cyc !== 185) begin errors++; $display("FAIL c45_rdinc_oe_fall: got %0d expected 185", oe_fall_cyc); end
        checks++; if (d !== 16'hBEEF || e !== 1'b0) begin errors++; $display("FAIL c45_rdinc_data: got dat=%h err=%b expected beef 0", d, e); end
        checks++; if (lat !== 257 || ok !== 1'b1) begin errors++; $display("FAIL c45_rdinc_timing: got lat=%0d ctl=%b expected 257 1", lat, ok); end
        phy_on = 1'b0;
    endtask

    task automatic test_illegal();
        int lat; logic e; logic [15:0] d; logic ok; int rises0;
        sel = 0;
        rises0 = mdc_rises;
        run_frame(1'b0, 2'b00, 5'h01, 5'h01, 16'h1111, 1'b0, lat, e, d, ok);
        checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL illegal_c22_cmd00: got lat=%0d err=%b expected 1 1", lat, e); end
        checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL illegal_dat_kept: got %h expected beef", d); end
        run_frame(1'b0, 2'b10, 5'h01, 5'h01, 16'h1111, 1'b0, lat, e, d, ok);
        checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL illegal_c22_cmd10: got lat=%0d err=%b expected 1 1", lat, e); end
        @(negedge clk);
        sel = 2;
        run_frame(1'b1, 2'b11, 5'h01, 5'h01, 16'h1111, 1'b0, lat, e, d, ok);
        checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL illegal_c45_unsupported: got lat=%0d err=%b expected 1 1", lat, e); end
        repeat (4) @(negedge clk);
        checks++; if (mdc_rises !== rises0) begin errors++; $display("FAIL illegal_no_mdc: got %0d rises expected %0d", mdc_rises, rises0); end
        sel = 0;
    endtask

    task automatic test_reset_mid_frame();
        int lat; logic e; logic [15:0] d; logic ok; int n;
        sel = 0; phy_on = 1'b0;
        @(negedge clk);
        c45 = 1'b0; cmd = 2'b01; pa = 5'h0A; ra = 5'h03; din = 16'hFFFF; cyc = 1'b1;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(cur_busy && rise_cnt > 52) && n < 2000);
        checks++; if (!(cur_busy && cur_oe)) begin errors++; $display("FAIL rst_mid_reached_data: got busy=%b oe=%b expected 1 1", cur_busy, cur_oe); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cur_mdc, cur_mdio, cur_oe, cur_ack, cur_err, cur_busy, cur_dat} !== {6'b010000, 16'h0000}) begin
            errors++;
            $display("FAIL rst_mid_values: got mdc=%b mdio=%b oe=%b ack=%b err=%b busy=%b dat=%h expected 0 1 0 0 0 0 0000",
                     cur_mdc, cur_mdio, cur_oe, cur_ack, cur_err, cur_busy, cur_dat);
        end
        cyc = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(1'b0, 2'b01, 5'h1F, 5'h1F, 16'hA5A5, 1'b0, lat, e, d, ok);
        checks++; if (lat !== 257 || e !== 1'b0 || ok !== 1'b1) begin errors++; $display("FAIL rst_mid_next_frame: got lat=%0d err=%b ctl=%b expected 257 0 1", lat, e, ok); end
        checks++; if (frame_bits !== 32'h5FFE_A5A5) begin errors++; $display("FAIL rst_mid_next_bits: got %h expected 5ffea5a5", frame_bits); end
    endtask

    task automatic test_back_to_back();
        int lat; logic e; logic [15:0] d; logic ok;
        @(negedge clk);
        sel = 1; phy_on = 1'b1; phy_data = 16'h2468;
        run_frame(1'b0, 2'b01, 5'h04, 5'h09, 16'h1357, 1'b1, lat, e, d, ok);
        checks++; if (lat !== 193 || e !== 1'b0 || ok !== 1'b1) begin errors++; $display("FAIL b2b_wr_timing: got lat=%0d err=%b ctl=%b expected 193 0 1", lat, e, ok); end
        checks++; if (frame_bits !== 32'h5226_1357) begin errors++; $display("FAIL b2b_wr_frame: got %h expected 52261357", frame_bits); end
        run_frame(1'b0, 2'b11, 5'h04, 5'h09, 16'h0000, 1'b0, lat, e, d, ok);
        checks++; if (lat !== 193 || ok !== 1'b1) begin errors++; $display("FAIL b2b_rd_timing: got lat=%0d ctl=%b expected 193 1", lat, ok); end
        checks++; if (frame_bits[31:18] !== 14'h1889) begin errors++; $display("FAIL b2b_rd_header: got %h expected 1889", frame_bits[31:18]); end
        checks++; if (oe_fall_cyc !== 85 || oe_lo_cnt !== 108) begin errors++; $display("FAIL b2b_rd_oe: got fall=%0d len=%0d expected 85 108", oe_fall_cyc, oe_lo_cnt); end
        checks++; if (d !== 16'h2468 || e !== 1'b0) begin errors++; $display("FAIL b2b_rd_data: got dat=%h err=%b expected 2468 0", d, e); end
        phy_on = 1'b0;
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_c22_write();
        test_c22_read();
        test_no_phy();
        test_c45();
        test_illegal();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
